// File: rtl/image_rom_pkg.sv
// Shared constants and helpers for the image ROM and its arbiters.
//   IMG_ADDR_W / IMG_DATA_W : ROM address ({y[5:0],x[5:0]}) and RGB444 data widths
//   IMG_W / IMG_H           : sprite sheet dimensions in pixels
//   idx_w()                 : index width for an N-way selector (never below 1 bit)
package image_rom_pkg;

   localparam int unsigned IMG_ADDR_W = 12;
   localparam int unsigned IMG_DATA_W = 12;
   localparam int unsigned IMG_W      = 48;
   localparam int unsigned IMG_H      = 64;

   typedef struct packed {
      logic [5:0] y;
      logic [5:0] x;
   } img_addr_t;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/image_rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, shared with other arbiters.
//   i_req    : per-requester request bits
//   i_ptr    : highest-priority index (must be < N_REQ)
//   o_onehot : one-hot winner, zero when no request
//   o_index  : binary winner index (0 when no request)
//   o_any    : at least one request present
module rr_pick
   import image_rom_pkg::*;
#(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IDX_W = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_onehot,
   output logic [IDX_W-1:0] o_index,
   output logic             o_any
);

   // Winner is the requester with the smallest rotated distance from the pointer,
   // with the distance taken modulo N_REQ so non-power-of-2 sizes wrap correctly.
   always_comb begin
      int v_dist;
      int v_best;
      v_dist   = 0;
      v_best   = int'(N_REQ);
      o_index  = '0;
      o_any    = 1'b0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (i_req[i]) begin
            v_dist = (i >= int'(i_ptr)) ? (i - int'(i_ptr))
                                        : (i + int'(N_REQ) - int'(i_ptr));
            if (v_dist < v_best) begin
               v_best  = v_dist;
               o_index = IDX_W'(i);
               o_any   = 1'b1;
            end
         end
      end
      o_onehot = o_any ? (N_REQ'(1) << o_index) : '0;
   end

endmodule

// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter: shares one synchronous image ROM (1-cycle read latency) between
// N_REQ pixel requesters with round-robin arbitration, one read per clock.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : per-requester level request
//   i_addr         : flat addresses, requester i at [i*ADDR_W +: ADDR_W]
//   i_lock         : (IMAGE_ROM_ARB_LOCK_EN only) owner keeps the ROM while req&lock held
//   o_gnt          : one-hot grant, same cycle as the winning request
//   o_rom_addr     : address to ROM
//   i_rom_rgb      : ROM registered output
//   o_rsp_valid    : one-hot tag, cycle after the matching grant
//   o_rsp_rgb      : read data (pass-through of i_rom_rgb)
// Build option: define IMAGE_ROM_ARB_LOCK_EN to add the burst-lock port.
module image_rom_arbiter
   import image_rom_pkg::*;
#(
   parameter int unsigned N_REQ  = 2,
   parameter int unsigned ADDR_W = IMG_ADDR_W,
   parameter int unsigned DATA_W = IMG_DATA_W
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*ADDR_W-1:0] i_addr,
`ifdef IMAGE_ROM_ARB_LOCK_EN
   input  logic [N_REQ-1:0]        i_lock,
`endif
   output logic [N_REQ-1:0]        o_gnt,
   output logic [ADDR_W-1:0]       o_rom_addr,
   input  logic [DATA_W-1:0]       i_rom_rgb,
   output logic [N_REQ-1:0]        o_rsp_valid,
   output logic [DATA_W-1:0]       o_rsp_rgb
);

   localparam int unsigned IDX_W = idx_w(N_REQ);

   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  w_ptr_next;
   logic [N_REQ-1:0]  r_rsp_valid;

   logic [N_REQ-1:0]  w_rr_onehot;
   logic [IDX_W-1:0]  w_rr_index;
   logic              w_rr_any;

   logic [N_REQ-1:0]  w_win_onehot;
   logic [IDX_W-1:0]  w_win_index;
   logic              w_win_any;
   logic              w_lock_hit;
   logic [ADDR_W-1:0] w_mux_addr;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_req    (i_req),
      .i_ptr    (r_ptr),
      .o_onehot (w_rr_onehot),
      .o_index  (w_rr_index),
      .o_any    (w_rr_any)
   );

`ifdef IMAGE_ROM_ARB_LOCK_EN
   // Owner is whoever won last cycle; "none" after reset or after an idle cycle.
   logic             r_own_vld;
   logic [IDX_W-1:0] r_own_idx;

   always_comb begin
      w_lock_hit = r_own_vld && i_req[r_own_idx] && i_lock[r_own_idx];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_own_vld <= 1'b0;
         r_own_idx <= '0;
      end else begin
         r_own_vld <= w_win_any;
         r_own_idx <= w_win_index;
      end
   end

   always_comb begin
      if (w_lock_hit) begin
         w_win_onehot = N_REQ'(1) << r_own_idx;
         w_win_index  = r_own_idx;
         w_win_any    = 1'b1;
      end else begin
         w_win_onehot = w_rr_onehot;
         w_win_index  = w_rr_index;
         w_win_any    = w_rr_any;
      end
   end
`else
   always_comb begin
      w_lock_hit   = 1'b0;
      w_win_onehot = w_rr_onehot;
      w_win_index  = w_rr_index;
      w_win_any    = w_rr_any;
   end
`endif

   // Pointer moves just past the winner; a locked burst leaves it untouched so the
   // round-robin order resumes where it left off.
   always_comb begin
      w_ptr_next = r_ptr;
      if (w_win_any && !w_lock_hit) begin
         if (w_win_index == IDX_W'(N_REQ - 1)) begin
            w_ptr_next = '0;
         end else begin
            w_ptr_next = w_win_index + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptr       <= '0;
         r_rsp_valid <= '0;
      end else begin
         r_ptr       <= w_ptr_next;
         r_rsp_valid <= w_win_onehot;
      end
   end

   always_comb begin
      w_mux_addr = '0;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (w_win_onehot[i]) begin
            w_mux_addr = w_mux_addr | i_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Grant and ROM address are held at zero while reset is asserted.
   always_comb begin
      o_gnt       = i_rst_n ? w_win_onehot : '0;
      o_rom_addr  = i_rst_n ? w_mux_addr : '0;
      o_rsp_valid = r_rsp_valid;
      o_rsp_rgb   = i_rom_rgb;
   end

endmodule

// File: tb/tb_image_rom_arbiter.sv
module tb_image_rom_arbiter;

   localparam int N  = 3;
   localparam int AW = 12;
   localparam int DW = 12;
`ifdef IMAGE_ROM_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N-1:0]    lock;
   logic [N*AW-1:0] addr;
   logic [N-1:0]    gnt;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_rgb;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_rgb;

   logic [DW-1:0]   rom [4096];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int           due;
      logic [N-1:0] vld;
      logic [DW-1:0] rgb;
   } exp_t;
   exp_t sbq[$];

   // Reference model state: priority pointer and last winner (-1 = none).
   int m_ptr;
   int m_own;

   image_rom_arbiter #(
      .N_REQ  (N),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_addr      (addr),
`ifdef IMAGE_ROM_ARB_LOCK_EN
      .i_lock      (lock),
`endif
      .o_gnt       (gnt),
      .o_rom_addr  (rom_addr),
      .i_rom_rgb   (rom_rgb),
      .o_rsp_valid (rsp_valid),
      .o_rsp_rgb   (rsp_rgb)
   );

   always #5 clk = ~clk;

   // Synchronous ROM model with one cycle of read latency.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rom_rgb <= rom[rom_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Drives one cycle of inputs, predicts the winner, queues the expected response.
   task automatic step(input logic [N-1:0] r, input logic [N*AW-1:0] a,
                       input logic [N-1:0] lk);
      int            w;
      int            idx;
      logic [N-1:0]  eg;
      logic [AW-1:0] ea;
      req  = r;
      addr = a;
      lock = lk;
      w    = -1;
      if (LOCK_EN && m_own >= 0 && ((r >> m_own) & 1) != 0 && ((lk >> m_own) & 1) != 0) begin
         w = m_own;
      end else begin
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && ((r >> idx) & 1) != 0) w = idx;
         end
         if (w >= 0) m_ptr = (w + 1) % N;
      end
      m_own = w;
      eg = (w >= 0) ? (N'(1) << w) : '0;
      ea = (w >= 0) ? AW'(a >> (w * AW)) : '0;
      if (w >= 0) sbq.push_back('{cyc + 1, eg, rom[ea]});
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("rom_addr", 32'(rom_addr), 32'(ea));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*AW-1:0] rand_addr();
      return {N*AW{1'b0}} | {$urandom, $urandom};
   endfunction

   // Monitor: pops the scoreboard whenever a response is due and checks invariants.
   always @(negedge clk) begin : mon
      exp_t e;
      chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      chk("rsp_onehot", 32'($countones(rsp_valid) <= 1), 32'd1);
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
         chk("rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
      end else begin
         chk("rsp_idle", 32'(rsp_valid), 32'd0);
      end
   end

   initial begin
      for (int i = 0; i < 4096; i++) rom[i] = DW'($urandom);
      req   = '0;
      addr  = '0;
      lock  = '0;
      m_ptr = 0;
      m_own = -1;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      req = '1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_gnt", 32'(gnt), 32'd0);
      chk("reset_rom_addr", 32'(rom_addr), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;

      // First grant after reset goes to requester 0.
      step(3'b111, rand_addr(), 3'b000);
      // Single requester with a known address.
      step(3'b010, {12'h3A7, 12'h0C5, 12'h111}, 3'b000);
      // Two-way contention alternates.
      repeat (6) step(3'b011, rand_addr(), 3'b000);
      // Three-way rotation wraps at 3.
      repeat (4) step(3'b111, rand_addr(), 3'b000);
      repeat (2) step(3'b000, rand_addr(), 3'b000);

      // Reset asserted while a response is in flight.
      step(3'b111, rand_addr(), 3'b000);
      rst_n = 1'b0;
      #1;
      chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midreset_gnt", 32'(gnt), 32'd0);
      chk("midreset_rom_addr", 32'(rom_addr), 32'd0);
      sbq.delete();
      m_ptr = 0;
      m_own = -1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(3'b111, rand_addr(), 3'b000);

      // Burst lock held by the last winner, then released.
      repeat (5) step(3'b011, rand_addr(), 3'b001);
      step(3'b011, rand_addr(), 3'b000);
      step(3'b011, rand_addr(), 3'b000);

      // Randomized traffic.
      repeat (400) begin
         logic [N-1:0] r;
         logic [N-1:0] lk;
         r  = N'($urandom);
         lk = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         step(r, rand_addr(), lk);
      end

      repeat (3) step(3'b000, rand_addr(), 3'b000);
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
